// File: rtl/barrel_shift_scheduler.sv
// barrel_shift_scheduler: round-robin front end for one shared, non-stalling, pipelined
// byte barrel shifter. Each operation carries a requester-id tag through a LAT-deep tag pipe.
// Results land in a credit-protected FIFO that is drained through a valid/ready handshake.
// Optional macro BSS_PERF_CNT_EN adds the saturating counters perf_issue_cnt and perf_stall_cnt.
module barrel_shift_scheduler #(
  parameter int unsigned K           = 16,
  parameter int unsigned SELECT_BITS = 4,
  parameter int unsigned LAT         = 4,
  parameter int unsigned NREQ        = 4,
  parameter int unsigned IDW         = 2,
  parameter int unsigned FIFO_DEPTH  = 8
) (
  input  logic                          clk,
  input  logic                          rstb,
  input  logic [NREQ-1:0]               req_valid,
  output logic [NREQ-1:0]               req_ready,
  input  logic [NREQ*8*K-1:0]           req_data,
  input  logic [NREQ*SELECT_BITS-1:0]   req_shamt,
  output logic [8*K-1:0]                sh_data_in,
  output logic [SELECT_BITS-1:0]        sh_select,
  input  logic [8*K-1:0]                sh_data_out,
  output logic                          res_valid,
  input  logic                          res_ready,
  output logic [8*K-1:0]                res_data,
  output logic [IDW-1:0]                res_id
`ifdef BSS_PERF_CNT_EN
  ,
  output logic [31:0]                   perf_issue_cnt,
  output logic [31:0]                   perf_stall_cnt
`endif
);

  localparam int unsigned W    = 8 * K;
  localparam int unsigned OCCW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned PTRW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [OCCW-1:0] OccMax  = OCCW'(FIFO_DEPTH);
  localparam logic [PTRW-1:0] PtrLast = PTRW'(FIFO_DEPTH - 1);

  // Arbitration and credit state
  logic [IDW-1:0]  rr_q;
  logic [OCCW-1:0] occ_q, occ_d;
  logic            any_valid;
  logic [IDW-1:0]  win_id;
  logic [IDW-1:0]  cand;
  logic            issue_ok;
  logic            issue;
  logic            pop;
  logic            push;

  // Tag pipe running alongside the shifter stages
  logic [LAT-1:0]  tag_vld_q;
  logic [IDW-1:0]  tag_id_q [LAT];

  // Result FIFO; res_* registers mirror the entry at rd_ptr_q
  logic [W+IDW-1:0] mem_q [FIFO_DEPTH];
  logic [PTRW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTRW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [OCCW-1:0]  cnt_q, cnt_d;
  logic [W+IDW-1:0] head_d;
  logic             bypass;

  function automatic logic [PTRW-1:0] ptr_inc(input logic [PTRW-1:0] ptr);
    return (ptr == PtrLast) ? '0 : ptr + 1'b1;
  endfunction

  // Issue gate: rstb is included so nothing is granted while reset is held
  assign issue_ok = rstb && (occ_q < OccMax);
  assign issue    = issue_ok && any_valid;
  assign pop      = res_valid && res_ready;
  assign push     = tag_vld_q[LAT-1];

  // Round-robin search starting after the last winner, plus shifter input muxing
  always_comb begin
    any_valid  = 1'b0;
    win_id     = '0;
    cand       = '0;
    req_ready  = '0;
    sh_data_in = '0;
    sh_select  = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand = IDW'((32'(rr_q) + k) % NREQ);
      if (!any_valid && req_valid[cand]) begin
        any_valid = 1'b1;
        win_id    = cand;
      end
    end
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (issue && (win_id == IDW'(k))) begin
        req_ready[k] = 1'b1;
        sh_data_in   = req_data[k*W +: W];
        sh_select    = req_shamt[k*SELECT_BITS +: SELECT_BITS];
      end
    end
  end

  // Occupancy: in-flight plus buffered; a pop is not credited to the same cycle's issue
  always_comb begin
    occ_d = occ_q;
    if (issue && !pop) begin
      occ_d = occ_q + 1'b1;
    end else if (!issue && pop) begin
      occ_d = occ_q - 1'b1;
    end
  end

  // Arbiter pointer and occupancy registers
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      rr_q  <= IDW'(NREQ - 1);
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
      if (issue) begin
        rr_q <= win_id;
      end
    end
  end

  // Tag pipe: stage 0 loads {issue, winner} every edge, matching the shifter's stage 0
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      tag_vld_q <= '0;
      for (int unsigned s = 0; s < LAT; s++) begin
        tag_id_q[s] <= '0;
      end
    end else begin
      tag_vld_q[0] <= issue;
      tag_id_q[0]  <= win_id;
      for (int unsigned s = 1; s < LAT; s++) begin
        tag_vld_q[s] <= tag_vld_q[s-1];
        tag_id_q[s]  <= tag_id_q[s-1];
      end
    end
  end

  // FIFO next state; the head bypasses memory when the pushed entry becomes the head at once
  always_comb begin
    cnt_d    = cnt_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      wr_ptr_d = ptr_inc(wr_ptr_q);
    end
    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    if (push && !pop) begin
      cnt_d = cnt_q + 1'b1;
    end else if (!push && pop) begin
      cnt_d = cnt_q - 1'b1;
    end
    bypass = push && ((cnt_q == '0) || (pop && (cnt_q == OCCW'(1))));
    if (cnt_d == '0) begin
      head_d = '0;
    end else if (bypass) begin
      head_d = {sh_data_out, tag_id_q[LAT-1]};
    end else begin
      head_d = mem_q[rd_ptr_d];
    end
  end

  // FIFO storage; only read at valid locations, so it carries no reset
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {sh_data_out, tag_id_q[LAT-1]};
    end
  end

  // FIFO pointers, count and registered head outputs
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_id    <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      res_valid <= (cnt_d != '0);
      res_data  <= head_d[W+IDW-1:IDW];
      res_id    <= head_d[IDW-1:0];
    end
  end

`ifdef BSS_PERF_CNT_EN
  // Saturating issue and stall counters
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      perf_issue_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (issue && (perf_issue_cnt != '1)) begin
        perf_issue_cnt <= perf_issue_cnt + 1'b1;
      end
      if ((|req_valid) && !issue_ok && (perf_stall_cnt != '1)) begin
        perf_stall_cnt <= perf_stall_cnt + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_barrel_shift_scheduler.sv
// Bench for barrel_shift_scheduler: directed vectors, with a pipelined shifter
// sitting beside the DUT and a result-order scoreboard.
module tb_barrel_shift_scheduler;
  localparam int K    = 16;
  localparam int SB   = 4;
  localparam int LAT  = 4;
  localparam int NREQ = 4;
  localparam int IDW  = 2;
  localparam int FD   = 8;
  localparam int W    = 8 * K;
  localparam int CW   = W + IDW;
  localparam logic [W-1:0] Base = 128'h0F0E0D0C0B0A09080706050403020100;

  logic                 clk = 1'b0;
  logic                 rstb = 1'b0;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*W-1:0]    req_data;
  logic [NREQ*SB-1:0]   req_shamt;
  logic [W-1:0]         sh_data_in;
  logic [SB-1:0]        sh_select;
  logic [W-1:0]         sh_data_out;
  logic                 res_valid;
  logic                 res_ready;
  logic [W-1:0]         res_data;
  logic [IDW-1:0]       res_id;

  int total = 0;
  int bad = 0;
  int rx_cnt = 0;
  logic [CW-1:0] exp_q [$];

  always #5 clk = ~clk;

  barrel_shift_scheduler #(
    .K(K), .SELECT_BITS(SB), .LAT(LAT), .NREQ(NREQ), .IDW(IDW), .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk), .rstb(rstb),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_data(req_data), .req_shamt(req_shamt),
    .sh_data_in(sh_data_in), .sh_select(sh_select), .sh_data_out(sh_data_out),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_id(res_id)
  );

  function automatic logic [W-1:0] rot(input logic [W-1:0] x, input int s);
    int b;
    b = 8 * (s % K);
    if (b == 0) return x;
    return (x << b) | (x >> (W - b));
  endfunction

  // Shared pipelined shifter: stage s rotates by 2**s bytes when select bit s is set
  logic [W-1:0]  st_data [LAT];
  logic [SB-1:0] st_sel  [LAT];
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      for (int s = 0; s < LAT; s++) begin
        st_data[s] <= '0;
        st_sel[s]  <= '0;
      end
    end else begin
      st_data[0] <= rot(sh_data_in, sh_select[0] ? 1 : 0);
      st_sel[0]  <= sh_select;
      for (int s = 1; s < LAT; s++) begin
        st_data[s] <= rot(st_data[s-1], st_sel[s-1][s] ? (1 << s) : 0);
        st_sel[s]  <= st_sel[s-1];
      end
    end
  end
  assign sh_data_out = st_data[LAT-1];

  task automatic check(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h, required %h", tag, got, exp);
    end
  endtask

  // Scoreboard: every accepted result must be the oldest outstanding expectation
  always @(negedge clk) begin
    if (rstb && res_valid && res_ready) begin
      rx_cnt++;
      if (exp_q.size() == 0) begin
        check("spurious_result", CW'(res_valid), '0);
      end else begin
        check("result", {res_data, res_id}, {exp_q[0][IDW +: W], exp_q[0][IDW-1:0]});
        void'(exp_q.pop_front());
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input string tag);
    for (int t = 0; t < 40 && exp_q.size() != 0; t++) next_cycle();
    check(tag, CW'(exp_q.size()), '0);
    next_cycle();
    next_cycle();
  endtask

  // One isolated request; result must appear exactly LAT+1 cycles after the grant
  task automatic single(input int rq, input logic [W-1:0] data, input int shamt,
                        input logic [W-1:0] exp);
    req_valid = '0;
    req_valid[rq] = 1'b1;
    req_data[rq*W +: W] = data;
    req_shamt[rq*SB +: SB] = SB'(shamt);
    exp_q.push_back({exp, IDW'(rq)});
    @(negedge clk);
    check("single_grant", CW'(req_ready), CW'(1 << rq));
    next_cycle();
    req_valid = '0;
    repeat (LAT - 1) next_cycle();
    @(negedge clk);
    check("single_not_early", CW'(res_valid), '0);
    next_cycle();
    @(negedge clk);
    check("single_latency", CW'(res_valid), CW'(1));
    next_cycle();
    @(negedge clk);
    check("single_popped", CW'(res_valid), '0);
    next_cycle();
  endtask

  function automatic logic [W-1:0] word4(input int i);
    return Base ^ {16{8'(16 * (i + 1))}};
  endfunction

  function automatic logic [W-1:0] mk(input int k);
    return {8'hA5, 112'(0), 8'(k)};
  endfunction

  initial begin
    req_valid = '1;
    req_data  = {NREQ{Base}};
    req_shamt = '1;
    res_ready = 1'b1;
    #3;
    check("rst_req_ready", CW'(req_ready), '0);
    check("rst_sh_data_in", CW'(sh_data_in), '0);
    check("rst_sh_select", CW'(sh_select), '0);
    check("rst_res_valid", CW'(res_valid), '0);
    check("rst_res_data", CW'(res_data), '0);
    check("rst_res_id", CW'(res_id), '0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rstb = 1'b1;
    req_valid = '0;
    req_data = '0;
    req_shamt = '0;
    next_cycle();

    // Isolated requests with hand-computed rotations
    single(0, Base, 1,  128'h0E0D0C0B0A090807060504030201000F);
    single(1, Base, 0,  Base);
    single(2, Base, 8,  128'h07060504030201000F0E0D0C0B0A0908);
    single(3, Base, 15, 128'h000F0E0D0C0B0A090807060504030201);

    // All requesters valid: rotating grants, one result per cycle
    res_ready = 1'b1;
    req_valid = '1;
    for (int i = 0; i < NREQ; i++) begin
      req_data[i*W +: W] = word4(i);
      req_shamt[i*SB +: SB] = SB'(4 * i + 3);
    end
    for (int k = 0; k < 13; k++) begin
      if (k < 8) exp_q.push_back({rot(word4(k % NREQ), 4 * (k % NREQ) + 3), IDW'(k % NREQ)});
      @(negedge clk);
      if (k < 8) check("rr_grant", CW'(req_ready), CW'(1 << (k % NREQ)));
      if (k >= 5) check("rr_throughput", CW'(res_valid), CW'(1));
      next_cycle();
      if (k == 7) req_valid = '0;
    end
    wait_drain("rr_drain");

    // Blocked consumer: exactly FD credits, then refill one per cycle
    res_ready = 1'b0;
    req_valid = 4'b0100;
    for (int k = 0; k < 14; k++) begin
      req_data[2*W +: W] = mk(k);
      req_shamt[2*SB +: SB] = SB'(k % 16);
      if (k < FD) exp_q.push_back({rot(mk(k), k % 16), IDW'(2)});
      @(negedge clk);
      check("credit_fill", CW'(req_ready), (k < FD) ? CW'(4) : '0);
      next_cycle();
    end
    res_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      req_data[2*W +: W] = mk(100 + k);
      req_shamt[2*SB +: SB] = SB'((100 + k) % 16);
      if (k > 0) exp_q.push_back({rot(mk(100 + k), (100 + k) % 16), IDW'(2)});
      @(negedge clk);
      check("credit_refill", CW'(req_ready), (k > 0) ? CW'(4) : '0);
      check("refill_valid", CW'(res_valid), CW'(1));
      next_cycle();
    end
    req_valid = '0;
    wait_drain("credit_drain");

    // Reset with 3 in flight and 2 buffered
    res_ready = 1'b0;
    req_valid = 4'b0001;
    req_data[0 +: W] = Base;
    req_shamt[0 +: SB] = SB'(5);
    repeat (5) next_cycle();
    req_valid = '0;
    next_cycle();
    req_valid = '1;
    rstb = 1'b0;
    #1;
    check("midrst_res_valid", CW'(res_valid), '0);
    check("midrst_req_ready", CW'(req_ready), '0);
    check("midrst_res_data", CW'(res_data), '0);
    exp_q.delete();
    next_cycle();
    next_cycle();
    rstb = 1'b1;
    res_ready = 1'b1;
    req_data[0 +: W] = Base;
    req_shamt[0 +: SB] = SB'(2);
    exp_q.push_back({128'h0D0C0B0A09080706050403020100_0F0E, IDW'(0)});
    @(negedge clk);
    check("post_rst_grant", CW'(req_ready), CW'(1));
    next_cycle();
    req_valid = '0;
    begin
      int lat;
      lat = 0;
      for (int t = 1; t <= 20 && lat == 0; t++) begin
        @(negedge clk);
        if (res_valid) lat = t;
        next_cycle();
      end
      check("post_rst_latency", CW'(lat), CW'(5));
    end
    wait_drain("post_rst_drain");
    check("result_count", CW'(rx_cnt), CW'(36));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
